game_ctrl: RTL and testbench

Game-state sequencer for the crossy-road VGA game. It sits between the raw button and pixel-level collision signals and the scroll/score datapath. It replaces the direct "collision → reset" path with a frame-synchronous state machine that handles attract, play, hit-freeze, respawn and game-over, and tracks lives and a high score. All decisions are taken once per video frame, so the datapath only changes during vertical blanking.

---
 rtl/crossy_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/game_ctrl.sv | 126 ++++++++++++
 tb/tb_game_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossy_pkg.sv
// rtl/crossy_pkg.sv - shared types and constants for the crossy-road game logic
package crossy_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_PLAY    = 3'd1,
        ST_HIT     = 3'd2,
        ST_RESPAWN = 3'd3,
        ST_OVER    = 3'd4
    } state_e;

    localparam int FRAME_LINE_DEF = 480;
    localparam int SCORE_W        = 8;

    // 12-bit RGB colours the display mux picks between using o_flash
    localparam logic [11:0] COLOR_CHICKEN = 12'hFF0;
    localparam logic [11:0] COLOR_FLASH   = 12'hFFF;

    function automatic logic [1:0] lives_dec(input logic [1:0] lives);
        return (lives == 2'd0) ? 2'd0 : lives - 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, frame-rate debounce and press detect
module btn_debounce (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_tick,
    output logic o_press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic samp_q, samp_d;
    logic level_q, level_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            samp_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            samp_q  <= samp_d;
            level_q <= level_d;
        end
    end

    // Level only follows two consecutive equal tick samples, so a one-frame glitch is ignored
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        samp_d  = samp_q;
        level_d = level_q;
        o_press = 1'b0;
        if (i_tick) begin
            samp_d = sync2_q;
            if (sync2_q == samp_q) begin
                level_d = sync2_q;
                o_press = sync2_q & ~level_q;
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - frame-synchronous game state sequencer with lives and high score
module game_ctrl
    import crossy_pkg::*;
#(
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 60,
    parameter int FRAME_LINE = FRAME_LINE_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [9:0]         i_hpos,
    input  logic [9:0]         i_vpos,
    input  logic               i_move_btn,
    input  logic               i_collide,
    input  logic [SCORE_W-1:0] i_score,
    output logic               o_game_rst,
    output logic               o_move,
    output logic               o_run,
    output logic               o_flash,
    output logic [1:0]         o_lives,
    output logic [SCORE_W-1:0] o_high_score,
    output logic [2:0]         o_state
);

    state_e             state_q, state_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               hit_latch_q, hit_latch_d;
    logic               game_rst_q, game_rst_d;
    logic               move_q, move_d;
    logic               run_q, run_d;
    logic               flash_q, flash_d;

    logic tick;
    logic press;
    logic hit_now;

    assign tick    = (i_vpos == 10'(FRAME_LINE)) && (i_hpos == 10'd0);
    // A collision on the tick cycle itself still counts for this frame
    assign hit_now = hit_latch_q | i_collide;

    btn_debounce u_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_move_btn),
        .i_tick  (tick),
        .o_press (press)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_ATTRACT;
            frame_cnt_q <= 8'd0;
            lives_q     <= 2'(LIVES);
            high_q      <= '0;
            hit_latch_q <= 1'b0;
            game_rst_q  <= 1'b1;
            move_q      <= 1'b0;
            run_q       <= 1'b0;
            flash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lives_q     <= lives_d;
            high_q      <= high_d;
            hit_latch_q <= hit_latch_d;
            game_rst_q  <= game_rst_d;
            move_q      <= move_d;
            run_q       <= run_d;
            flash_q     <= flash_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        high_d      = high_q;
        hit_latch_d = tick ? 1'b0 : hit_now;
        if (tick) begin
            case (state_q)
                ST_ATTRACT: if (press) begin
                    state_d = ST_PLAY;
                    lives_d = 2'(LIVES);
                end
                ST_PLAY: if (hit_now) begin
                    state_d = ST_HIT;
                    lives_d = lives_dec(lives_q);
                    if (i_score > high_q) high_d = i_score;
                end
                ST_HIT: if (frame_cnt_q == 8'(HIT_FRAMES - 1)) begin
                    state_d = (lives_q == 2'd0) ? ST_OVER : ST_RESPAWN;
                end
                ST_RESPAWN: state_d = ST_PLAY;
                ST_OVER: if (press) begin
                    state_d = ST_RESPAWN;
                    lives_d = 2'(LIVES);
                end
                default: state_d = ST_ATTRACT;
            endcase
        end
        frame_cnt_d = frame_cnt_q;
        if (state_d != state_q) begin
            frame_cnt_d = 8'd0;
        end else if (tick && state_q == ST_HIT && frame_cnt_q != 8'hFF) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Outputs are decoded from the next state so they change together with it
    always_comb begin
        game_rst_d = (state_d == ST_ATTRACT) || (state_d == ST_RESPAWN);
        run_d      = (state_d == ST_PLAY);
        flash_d    = (state_d == ST_HIT) && frame_cnt_d[3];
        move_d     = tick && (state_q == ST_PLAY) && press && !hit_now;
    end

    assign o_game_rst   = game_rst_q;
    assign o_move       = move_q;
    assign o_run        = run_q;
    assign o_flash      = flash_q;
    assign o_lives      = lives_q;
    assign o_high_score = high_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - self-checking bench for game_ctrl against a frame-level game model
module tb_game_ctrl;

    localparam int LIVES      = 3;
    localparam int HIT_FRAMES = 60;
    localparam int FRAME_LINE = 480;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [9:0] i_hpos = 10'd0;
    logic [9:0] i_vpos = 10'd475;
    logic       i_move_btn = 1'b0;
    logic       i_collide = 1'b0;
    logic [7:0] i_score = 8'd0;
    logic       o_game_rst, o_move, o_run, o_flash;
    logic [1:0] o_lives;
    logic [7:0] o_high_score;
    logic [2:0] o_state;

    game_ctrl #(.LIVES(LIVES), .HIT_FRAMES(HIT_FRAMES), .FRAME_LINE(FRAME_LINE)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_hpos       (i_hpos),
        .i_vpos       (i_vpos),
        .i_move_btn   (i_move_btn),
        .i_collide    (i_collide),
        .i_score      (i_score),
        .o_game_rst   (o_game_rst),
        .o_move       (o_move),
        .o_run        (o_run),
        .o_flash      (o_flash),
        .o_lives      (o_lives),
        .o_high_score (o_high_score),
        .o_state      (o_state)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int tick_count = 0;
    int move_count = 0;

    // model state: 0 attract, 1 play, 2 hit, 3 respawn, 4 over
    int m_state = 0;
    int m_lives = LIVES;
    int m_hs    = 0;
    int m_cnt   = 0;
    int m_move  = 0;
    int m_latch = 0;
    int m_prev  = 0;
    int m_level = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compressed raster: 8 columns x 8 lines per frame, tick at line 480 column 0
    initial forever begin
        @(negedge i_clk);
        if (i_hpos == 10'd7) begin
            i_hpos = 10'd0;
            i_vpos = (i_vpos == 10'd482) ? 10'd475 : i_vpos + 10'd1;
        end else begin
            i_hpos = i_hpos + 10'd1;
        end
    end

    initial forever begin
        int hit, smp, press;
        @(posedge i_clk or negedge i_rst_n);
        if (!i_rst_n) begin
            m_state = 0; m_lives = LIVES; m_hs = 0; m_cnt = 0;
            m_move = 0; m_latch = 0; m_prev = 0; m_level = 0;
        end else if (i_clk) begin
            m_move = 0;
            hit = (m_latch != 0 || i_collide) ? 1 : 0;
            if (!(i_vpos == 10'(FRAME_LINE) && i_hpos == 10'd0)) begin
                m_latch = hit;
            end else begin
                m_latch = 0;
                tick_count++;
                smp = i_move_btn ? 1 : 0;
                press = 0;
                if (smp == m_prev) begin
                    press = (smp == 1 && m_level == 0) ? 1 : 0;
                    m_level = smp;
                end
                m_prev = smp;
                case (m_state)
                    0: if (press != 0) begin m_state = 1; m_lives = LIVES; end
                    1: begin
                        if (hit != 0) begin
                            m_state = 2; m_cnt = 0;
                            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                            if (int'(i_score) > m_hs) m_hs = int'(i_score);
                        end else if (press != 0) begin
                            m_move = 1;
                        end
                    end
                    2: begin
                        m_cnt++;
                        if (m_cnt == HIT_FRAMES) begin
                            m_cnt = 0;
                            m_state = (m_lives == 0) ? 4 : 3;
                        end
                    end
                    3: m_state = 1;
                    4: if (press != 0) begin m_state = 3; m_lives = LIVES; end
                    default: m_state = 0;
                endcase
            end
        end
    end

    initial forever begin
        @(negedge i_clk);
        if (o_move) move_count++;
        check("state",    int'(o_state),      m_state);
        check("game_rst", int'(o_game_rst),   (m_state == 0 || m_state == 3) ? 1 : 0);
        check("run",      int'(o_run),        (m_state == 1) ? 1 : 0);
        check("flash",    int'(o_flash),      (m_state == 2 && ((m_cnt / 8) % 2) == 1) ? 1 : 0);
        check("move",     int'(o_move),       m_move);
        check("lives",    int'(o_lives),      m_lives);
        check("high",     int'(o_high_score), m_hs);
    end

    task automatic wait_ticks(input int n);
        int target = tick_count + n;
        int budget = n * 64 + 80;
        while (tick_count < target && budget > 0) begin
            @(negedge i_clk);
            budget--;
        end
        n_checks++;
        if (tick_count < target) begin
            n_errors++;
            $display("FAIL tick_timeout: got %0d ticks expected %0d", tick_count, target);
        end
    endtask

    task automatic collide_pulse(input int score);
        i_score = 8'(score);
        repeat (20) @(negedge i_clk);
        i_collide = 1'b1;
        @(negedge i_clk);
        i_collide = 1'b0;
        wait_ticks(1);
    endtask

    initial begin
        int mc0;
        repeat (3) @(negedge i_clk);
        check("rst_state", int'(o_state), 0);
        check("rst_game_rst", int'(o_game_rst), 1);
        check("rst_lives", int'(o_lives), 3);
        check("rst_high", int'(o_high_score), 0);
        check("rst_move", int'(o_move), 0);
        #2 i_rst_n = 1'b1;
        wait_ticks(1);
        check("idle_state", int'(o_state), 0);

        i_move_btn = 1'b1;
        wait_ticks(1);
        i_move_btn = 1'b0;
        wait_ticks(3);
        check("glitch_state", int'(o_state), 0);

        mc0 = move_count;
        i_move_btn = 1'b1;
        wait_ticks(1);
        check("start_tick1", int'(o_state), 0);
        wait_ticks(1);
        check("start_state", int'(o_state), 1);
        check("start_game_rst", int'(o_game_rst), 0);
        wait_ticks(1);
        i_move_btn = 1'b0;
        wait_ticks(2);
        check("start_no_move", move_count - mc0, 0);

        mc0 = move_count;
        i_move_btn = 1'b1;
        wait_ticks(10);
        check("move_one", move_count - mc0, 1);
        i_move_btn = 1'b0;
        wait_ticks(2);
        i_move_btn = 1'b1;
        wait_ticks(3);
        check("move_two", move_count - mc0, 2);
        i_move_btn = 1'b0;
        wait_ticks(2);

        collide_pulse(5);
        check("hit_state", int'(o_state), 2);
        check("hit_lives", int'(o_lives), 2);
        check("hit_high", int'(o_high_score), 5);
        check("hit_run", int'(o_run), 0);
        wait_ticks(HIT_FRAMES - 1);
        check("hit_hold", int'(o_state), 2);
        wait_ticks(1);
        check("respawn_state", int'(o_state), 3);
        check("respawn_rst", int'(o_game_rst), 1);
        wait_ticks(1);
        check("replay_state", int'(o_state), 1);
        check("replay_rst", int'(o_game_rst), 0);

        collide_pulse(2);
        check("hit2_lives", int'(o_lives), 1);
        check("hit2_high", int'(o_high_score), 5);
        wait_ticks(HIT_FRAMES + 1);
        check("hit2_play", int'(o_state), 1);

        collide_pulse(3);
        check("hit3_lives", int'(o_lives), 0);
        check("hit3_high", int'(o_high_score), 5);
        wait_ticks(HIT_FRAMES);
        check("over_state", int'(o_state), 4);
        check("over_run", int'(o_run), 0);
        check("over_rst", int'(o_game_rst), 0);
        i_move_btn = 1'b1;
        wait_ticks(2);
        check("over_press", int'(o_state), 3);
        check("over_lives", int'(o_lives), 3);
        i_move_btn = 1'b0;
        wait_ticks(1);
        check("over_play", int'(o_state), 1);
        wait_ticks(1);

        mc0 = move_count;
        i_move_btn = 1'b1;
        wait_ticks(1);
        i_collide = 1'b1;
        wait_ticks(1);
        i_collide = 1'b0;
        check("both_state", int'(o_state), 2);
        check("both_lives", int'(o_lives), 2);
        check("both_no_move", move_count - mc0, 0);
        i_move_btn = 1'b0;
        wait_ticks(5);

        #2 i_rst_n = 1'b0;
        @(negedge i_clk);
        check("midrst_state", int'(o_state), 0);
        check("midrst_rst", int'(o_game_rst), 1);
        check("midrst_lives", int'(o_lives), 3);
        check("midrst_high", int'(o_high_score), 0);
        check("midrst_flash", int'(o_flash), 0);
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        wait_ticks(2);
        check("post_rst_state", int'(o_state), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
